// File: rtl/hsiao_secded_dec_pipe_if.sv
// rtl/hsiao_secded_dec_pipe_if.sv - beat stream bundle for the pipelined SECDED decoder
// Lane k occupies code bits [72k +: 72] / data bits [64k +: 64], bit 0 is the MSB.
interface hsiao_secded_dec_pipe_if #(
  parameter int LANES = 2
);
  logic                  i_valid;
  logic                  o_ready;
  logic [0:72*LANES-1]   i_code;
  logic                  i_corr_en;
  logic                  o_valid;
  logic                  i_ready;
  logic [0:64*LANES-1]   o_data;
  logic [LANES-1:0]      o_err_corr;
  logic [LANES-1:0]      o_err_chk;
  logic [LANES-1:0]      o_err_fatal;

  modport slave (
    input  i_valid, i_code, i_corr_en, i_ready,
    output o_ready, o_valid, o_data, o_err_corr, o_err_chk, o_err_fatal
  );

  modport master (
    output i_valid, i_code, i_corr_en, i_ready,
    input  o_ready, o_valid, o_data, o_err_corr, o_err_chk, o_err_fatal
  );
endinterface

// File: rtl/hsiao_secded_dec_pipe.sv
// rtl/hsiao_secded_dec_pipe.sv - two-stage multi-lane Hsiao (72,64) SECDED decoder
// Stage 1 holds the raw beat, stage 2 holds decoded data, flags, counters feed and first-error capture.
module hsiao_secded_dec_pipe #(
  parameter int LANES = 2,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  hsiao_secded_dec_pipe_if.slave bus,
  input  logic                  i_cnt_clr,
  output logic [CNT_W-1:0]      o_cnt_corr,
  output logic [CNT_W-1:0]      o_cnt_fatal,
  input  logic                  i_first_clr,
  output logic                  o_first_vld,
  output logic [2:0]            o_first_lane,
  output logic [7:0]            o_first_synd,
  output logic                  o_first_fatal
);

  localparam int CW = 72 * LANES;
  localparam int DW = 64 * LANES;

  // Data-column signatures, column 0 in the top byte; check bit 64+c owns syndrome bit 7-c.
  localparam logic [511:0] H_COLS = {
    8'hC4, 8'hC2, 8'hC1, 8'hB0, 8'hA8, 8'hA4, 8'hA2, 8'hA1,
    8'h98, 8'h94, 8'h92, 8'h91, 8'h8C, 8'h8A, 8'h89, 8'h86,
    8'h85, 8'h83, 8'h70, 8'h68, 8'h64, 8'h62, 8'h61, 8'h58,
    8'h54, 8'h52, 8'h51, 8'h4C, 8'h4A, 8'h49, 8'h46, 8'h45,
    8'h43, 8'h38, 8'h34, 8'h32, 8'h31, 8'h2C, 8'h2A, 8'h29,
    8'h26, 8'h23, 8'h1C, 8'h1A, 8'h19, 8'h16, 8'h15, 8'h13,
    8'h0E, 8'h0D, 8'h0B, 8'h07, 8'hE0, 8'hD0, 8'hC8, 8'hF8,
    8'h7C, 8'h3E, 8'h1F, 8'h8F, 8'hC7, 8'hE3, 8'hF1, 8'h25
  };

  function automatic logic [7:0] hcol(input int j);
    return H_COLS[511-8*j -: 8];
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [3:0] n);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {{(CNT_W-3){1'b0}}, n};
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  logic                s1_full_q,     s1_full_d;
  logic [0:CW-1]       s1_code_q,     s1_code_d;
  logic                s1_corr_en_q,  s1_corr_en_d;
  logic                s2_full_q,     s2_full_d;
  logic [0:DW-1]       s2_data_q,     s2_data_d;
  logic [LANES-1:0]    s2_corr_q,     s2_corr_d;
  logic [LANES-1:0]    s2_chk_q,      s2_chk_d;
  logic [LANES-1:0]    s2_fatal_q,    s2_fatal_d;
  logic [CNT_W-1:0]    cnt_corr_q,    cnt_corr_d;
  logic [CNT_W-1:0]    cnt_fatal_q,   cnt_fatal_d;
  logic                first_vld_q,   first_vld_d;
  logic [2:0]          first_lane_q,  first_lane_d;
  logic [7:0]          first_synd_q,  first_synd_d;
  logic                first_fatal_q, first_fatal_d;

  logic s1_moves;
  logic accept;
  logic s2_load;

  // Stage 1 may advance whenever stage 2 is empty or being drained this cycle.
  assign s1_moves    = ~s2_full_q | bus.i_ready;
  assign bus.o_ready = ~s1_full_q | s1_moves;
  assign accept      = bus.i_valid & bus.o_ready;
  assign s2_load     = s1_full_q & s1_moves;

  logic [0:DW-1]      dec_data;
  logic [LANES-1:0]   dec_corr;
  logic [LANES-1:0]   dec_chk;
  logic [LANES-1:0]   dec_fatal;
  logic [8*LANES-1:0] dec_synd;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [0:63] rx_data;
    logic [7:0]  rx_chk;
    logic [7:0]  synd;
    logic [0:63] flip;
    logic        data_hit;
    logic        chk_hit;

    assign rx_data = s1_code_q[72*k +: 64];
    assign rx_chk  = s1_code_q[72*k+64 +: 8];

    always_comb begin
      synd = rx_chk;
      for (int j = 0; j < 64; j++) begin
        if (rx_data[j]) synd = synd ^ hcol(j);
      end
    end

    always_comb begin
      flip = '0;
      for (int j = 0; j < 64; j++) begin
        flip[j] = (synd == hcol(j));
      end
    end

    assign data_hit = |flip;
    assign chk_hit  = $onehot(synd);

    assign dec_data[64*k +: 64]  = rx_data ^ (s1_corr_en_q ? flip : 64'd0);
    assign dec_corr[k]           = data_hit | chk_hit;
    assign dec_chk[k]            = chk_hit;
    assign dec_fatal[k]          = (synd != 8'd0) & ~data_hit & ~chk_hit;
    assign dec_synd[8*k +: 8]    = synd;
  end

  logic       any_flag;
  logic [2:0] lo_lane;
  logic [7:0] lo_synd;
  logic       lo_fatal;
  logic [3:0] n_corr;
  logic [3:0] n_fatal;

  assign any_flag = |(dec_corr | dec_fatal);
  assign n_corr   = 4'($countones(dec_corr));
  assign n_fatal  = 4'($countones(dec_fatal));

  // Scan from the top lane down so the lowest flagged lane is the one left standing.
  always_comb begin
    lo_lane  = 3'd0;
    lo_synd  = 8'd0;
    lo_fatal = 1'b0;
    for (int k = LANES - 1; k >= 0; k--) begin
      if (dec_corr[k] | dec_fatal[k]) begin
        lo_lane  = 3'(k);
        lo_synd  = dec_synd[8*k +: 8];
        lo_fatal = dec_fatal[k];
      end
    end
  end

  always_comb begin
    s1_full_d     = s1_full_q;
    s1_code_d     = s1_code_q;
    s1_corr_en_d  = s1_corr_en_q;
    s2_full_d     = s2_full_q;
    s2_data_d     = s2_data_q;
    s2_corr_d     = s2_corr_q;
    s2_chk_d      = s2_chk_q;
    s2_fatal_d    = s2_fatal_q;
    cnt_corr_d    = cnt_corr_q;
    cnt_fatal_d   = cnt_fatal_q;
    first_vld_d   = first_vld_q;
    first_lane_d  = first_lane_q;
    first_synd_d  = first_synd_q;
    first_fatal_d = first_fatal_q;

    if (bus.o_ready) begin
      s1_full_d = accept;
      if (accept) begin
        s1_code_d    = bus.i_code;
        s1_corr_en_d = bus.i_corr_en;
      end
    end

    if (s1_moves) begin
      s2_full_d = s1_full_q;
      if (s1_full_q) begin
        s2_data_d  = dec_data;
        s2_corr_d  = dec_corr;
        s2_chk_d   = dec_chk;
        s2_fatal_d = dec_fatal;
      end
    end

    // Counting on the load edge only, so a stalled beat is never counted twice.
    if (i_cnt_clr) begin
      cnt_corr_d  = '0;
      cnt_fatal_d = '0;
    end else if (s2_load) begin
      cnt_corr_d  = sat_add(cnt_corr_q, n_corr);
      cnt_fatal_d = sat_add(cnt_fatal_q, n_fatal);
    end

    if (s2_load & any_flag & (~first_vld_q | i_first_clr)) begin
      first_vld_d   = 1'b1;
      first_lane_d  = lo_lane;
      first_synd_d  = lo_synd;
      first_fatal_d = lo_fatal;
    end else if (i_first_clr) begin
      first_vld_d   = 1'b0;
      first_lane_d  = 3'd0;
      first_synd_d  = 8'd0;
      first_fatal_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_full_q     <= 1'b0;
      s1_code_q     <= '0;
      s1_corr_en_q  <= 1'b0;
      s2_full_q     <= 1'b0;
      s2_data_q     <= '0;
      s2_corr_q     <= '0;
      s2_chk_q      <= '0;
      s2_fatal_q    <= '0;
      cnt_corr_q    <= '0;
      cnt_fatal_q   <= '0;
      first_vld_q   <= 1'b0;
      first_lane_q  <= 3'd0;
      first_synd_q  <= 8'd0;
      first_fatal_q <= 1'b0;
    end else begin
      s1_full_q     <= s1_full_d;
      s1_code_q     <= s1_code_d;
      s1_corr_en_q  <= s1_corr_en_d;
      s2_full_q     <= s2_full_d;
      s2_data_q     <= s2_data_d;
      s2_corr_q     <= s2_corr_d;
      s2_chk_q      <= s2_chk_d;
      s2_fatal_q    <= s2_fatal_d;
      cnt_corr_q    <= cnt_corr_d;
      cnt_fatal_q   <= cnt_fatal_d;
      first_vld_q   <= first_vld_d;
      first_lane_q  <= first_lane_d;
      first_synd_q  <= first_synd_d;
      first_fatal_q <= first_fatal_d;
    end
  end

  assign bus.o_valid     = s2_full_q;
  assign bus.o_data      = s2_data_q;
  assign bus.o_err_corr  = s2_corr_q;
  assign bus.o_err_chk   = s2_chk_q;
  assign bus.o_err_fatal = s2_fatal_q;
  assign o_cnt_corr      = cnt_corr_q;
  assign o_cnt_fatal     = cnt_fatal_q;
  assign o_first_vld     = first_vld_q;
  assign o_first_lane    = first_lane_q;
  assign o_first_synd    = first_synd_q;
  assign o_first_fatal   = first_fatal_q;

endmodule
